// File: rtl/decode_stage_if.sv
// Shared decode types plus the fetch-in / decoded-out bus of decode_stage.
// The stage takes the slave view, the fetch producer and decode consumer take the master view.
package decode_stage_pkg;
    localparam int unsigned DEC_XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_t;

    typedef struct packed {
        logic [DEC_XLEN-1:0] pc;
        logic [DEC_XLEN-1:0] instr;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        imm_t                imm_type;
        logic [DEC_XLEN-1:0] imm;
        logic                rd_we;
        logic                illegal;
    } dec_entry_t;
endpackage

interface decode_stage_if;
    import decode_stage_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DEC_XLEN-1:0] pc;
    logic [DEC_XLEN-1:0] instr;

    logic                out_valid;
    logic                out_ready;
    logic [DEC_XLEN-1:0] out_pc;
    logic [DEC_XLEN-1:0] out_instr;
    logic [4:0]          addr_rd;
    logic [4:0]          addr_rs1;
    logic [4:0]          addr_rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    imm_t                imm_type;
    logic [DEC_XLEN-1:0] imm;
    logic                rd_we;
    logic                illegal;

    modport slave (
        input  in_valid, pc, instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, addr_rd, addr_rs1, addr_rs2,
               funct3, funct7, imm_type, imm, rd_we, illegal
    );

    modport master (
        output in_valid, pc, instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, addr_rd, addr_rs1, addr_rs2,
               funct3, funct7, imm_type, imm, rd_we, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a DEPTH-entry decoded-result queue and flush.
// Define DECODE_MULDIV_EN to accept the M-extension Op encodings (funct7=0000001).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    decode_stage_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    if (XLEN != 32) begin : g_xlen_chk
        $error("decode_stage: XLEN must be 32");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
        $error("decode_stage: DEPTH must be 1..4");
    end

    function automatic dec_entry_t decode(input logic [31:0] pc, input logic [31:0] instr);
        dec_entry_t e;
        logic       ok;
        logic       we;
        e          = '0;
        e.pc       = pc;
        e.instr    = instr;
        e.rd       = instr[11:7];
        e.rs1      = instr[19:15];
        e.rs2      = instr[24:20];
        e.funct3   = instr[14:12];
        e.funct7   = instr[31:25];
        e.imm_type = IMM_I;
        ok         = 1'b1;
        we         = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin e.imm_type = IMM_U; we = 1'b1; end
            OPC_JAL:            begin e.imm_type = IMM_J; we = 1'b1; end
            OPC_JALR:           begin we = 1'b1; ok = (e.funct3 == 3'b000); end
            OPC_BRANCH:         begin e.imm_type = IMM_B; ok = !(e.funct3 inside {3'b010, 3'b011}); end
            OPC_LOAD:           begin we = 1'b1; ok = !(e.funct3 inside {3'b011, 3'b110, 3'b111}); end
            OPC_STORE:          begin e.imm_type = IMM_S; ok = (e.funct3 <= 3'b010); end
            OPC_OPIMM: begin
                we = 1'b1;
                if (e.funct3 == 3'b001)      ok = (e.funct7 == 7'b0000000);
                else if (e.funct3 == 3'b101) ok = (e.funct7 == 7'b0000000) || (e.funct7 == 7'b0100000);
            end
            OPC_OP: begin
                we = 1'b1;
                case (e.funct7)
                    7'b0000000: ok = 1'b1;
                    7'b0100000: ok = (e.funct3 == 3'b000) || (e.funct3 == 3'b101);
`ifdef DECODE_MULDIV_EN
                    7'b0000001: ok = 1'b1;
`endif
                    default:    ok = 1'b0;
                endcase
            end
            OPC_MISCMEM, OPC_SYSTEM: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        if (instr[1:0] != 2'b11) ok = 1'b0;
        case (e.imm_type)
            IMM_S:   e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   e.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   e.imm = {instr[31:12], 12'b0};
            IMM_J:   e.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: e.imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        e.illegal = !ok;
        e.rd_we   = we && ok && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    dec_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    dec_entry_t        in_dec;
    dec_entry_t        head;
    logic              out_valid;
    logic              in_ready;
    logic              push;
    logic              pop;
    logic              wr_en;

    assign in_dec    = decode(bus.pc, bus.instr);
    assign out_valid = (count_q != '0);
    assign in_ready  = !rst_i && ((count_q < CNT_W'(DEPTH)) || (bus.out_ready && out_valid));
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Flush wins over push/pop; a word accepted in the flush cycle is dropped.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = ptr_inc(head_q);
            if (push) begin
                tail_d = ptr_inc(tail_q);
                wr_en  = 1'b1;
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (wr_en) mem_q[tail_q] <= in_dec;
        end
    end

    assign head          = mem_q[head_q];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.addr_rd   = head.rd;
    assign bus.addr_rs1  = head.rs1;
    assign bus.addr_rs2  = head.rs2;
    assign bus.funct3    = head.funct3;
    assign bus.funct7    = head.funct7;
    assign bus.imm_type  = head.imm_type;
    assign bus.imm       = head.imm;
    assign bus.rd_we     = head.rd_we;
    assign bus.illegal   = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef DECODE_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    decode_stage_if bus();

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  ityp;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   live  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode built from the instruction-set rules, immediates via arithmetic shifts.
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        bit   legal;
        bit   writes;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e.pc = pc;  e.instr = ins;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.f3 = f3;  e.f7 = f7;
        e.ityp = 3'(IMM_I);
        legal = 1'b1; writes = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin e.ityp = 3'(IMM_U); writes = 1'b1; end
            7'h6F:        begin e.ityp = 3'(IMM_J); writes = 1'b1; end
            7'h67:        begin writes = 1'b1; legal = (f3 == 3'd0); end
            7'h63:        begin e.ityp = 3'(IMM_B); legal = (f3 != 3'd2) && (f3 != 3'd3); end
            7'h03:        begin writes = 1'b1; legal = (f3 < 3'd3) || (f3 == 3'd4) || (f3 == 3'd5); end
            7'h23:        begin e.ityp = 3'(IMM_S); legal = (f3 < 3'd3); end
            7'h13: begin
                writes = 1'b1;
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h33: begin
                writes = 1'b1;
                legal  = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5))
                         || (MULDIV && f7 == 7'h01);
            end
            7'h0F, 7'h73: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        case (e.ityp)
            3'(IMM_S): e.imm = 32'($signed({ins[31:25], ins[11:7], 20'b0}) >>> 20);
            3'(IMM_B): e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19);
            3'(IMM_U): e.imm = ins & 32'hFFFF_F000;
            3'(IMM_J): e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11);
            default:   e.imm = 32'($signed(ins) >>> 20);
        endcase
        e.ill = !legal;
        e.we  = writes && legal && (e.rd != 5'd0);
        return e;
    endfunction

    // Model update on every active edge.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            q.delete();
            live <= 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            do_pop  = bus.out_ready && (q.size() > 0);
            do_push = bus.in_valid && ((q.size() < DEPTH) || do_pop);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(model(bus.pc, bus.instr));
        end
    end

    // Compare DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!rst && ((q.size() < DEPTH) || (bus.out_ready && q.size() > 0))));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("pc",       bus.out_pc,            q[0].pc);
                chk("instr",    bus.out_instr,         q[0].instr);
                chk("rd",       32'(bus.addr_rd),      32'(q[0].rd));
                chk("rs1",      32'(bus.addr_rs1),     32'(q[0].rs1));
                chk("rs2",      32'(bus.addr_rs2),     32'(q[0].rs2));
                chk("funct3",   32'(bus.funct3),       32'(q[0].f3));
                chk("funct7",   32'(bus.funct7),       32'(q[0].f7));
                chk("imm_type", 32'(bus.imm_type),     32'(q[0].ityp));
                chk("imm",      bus.imm,               q[0].imm);
                chk("rd_we",    32'(bus.rd_we),        32'(q[0].we));
                chk("illegal",  32'(bus.illegal),      32'(q[0].ill));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = v;
        bus.pc       = pc;
        bus.instr    = instr;
    endtask

    logic [31:0] vec [20] = '{
        32'h123452B7, 32'h00000017, 32'h000100E7, 32'h000110E7, 32'hFE208CE3,
        32'h00822183, 32'h00823183, 32'h402081B3, 32'h4020D1B3, 32'h042081B3,
        32'h402091B3, 32'h40109093, 32'h4010D093, 32'h0000000F, 32'h00000073,
        32'h0000007B, 32'h00004501, 32'h0051B023, 32'h00112063, 32'h00518023
    };

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc(); cyc();
        at_neg();
        chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_pc",        bus.out_pc,         32'h0);
        chk("rst_imm",       bus.imm,            32'h0);
        cyc();
        rst = 1'b0;

        // addi x1,x2,-1
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'hFFF10093);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        at_neg();
        chk("addi_valid", 32'(bus.out_valid), 32'h1);
        chk("addi_pc",    bus.out_pc,         32'h100);
        chk("addi_rd",    32'(bus.addr_rd),   32'd1);
        chk("addi_rs1",   32'(bus.addr_rs1),  32'd2);
        chk("addi_f3",    32'(bus.funct3),    32'd0);
        chk("addi_type",  32'(bus.imm_type),  32'(IMM_I));
        chk("addi_imm",   bus.imm,            32'hFFFF_FFFF);
        chk("addi_we",    32'(bus.rd_we),     32'h1);
        chk("addi_ill",   32'(bus.illegal),   32'h0);
        cyc();

        // sw x5,-4(x6)
        drive(1'b1, 32'h104, 32'hFE532E23);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        at_neg();
        chk("sw_type", 32'(bus.imm_type), 32'(IMM_S));
        chk("sw_imm",  bus.imm,           32'hFFFF_FFFC);
        chk("sw_rs1",  32'(bus.addr_rs1), 32'd6);
        chk("sw_rs2",  32'(bus.addr_rs2), 32'd5);
        chk("sw_we",   32'(bus.rd_we),    32'h0);
        cyc();

        // Back-pressure: fill, then push and pop together while full
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h00100093);
        cyc();
        drive(1'b1, 32'h204, 32'h00200113);
        cyc();
        drive(1'b1, 32'h208, 32'h00300193);
        at_neg();
        chk("full_ready", 32'(bus.in_ready), 32'h0);
        chk("full_head",  bus.out_pc,        32'h200);
        cyc();
        bus.out_ready = 1'b1;
        at_neg();
        chk("full_pop_ready", 32'(bus.in_ready), 32'h1);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        at_neg();
        chk("pp_head",  bus.out_pc,        32'h204);
        chk("pp_count", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        cyc();
        at_neg();
        chk("pp_tail", bus.out_pc, 32'h208);
        cyc();
        at_neg();
        chk("drained", 32'(bus.out_valid), 32'h0);

        // Flush with two buffered entries and an accepted input
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h00100093);
        cyc();
        drive(1'b1, 32'h304, 32'h00200113);
        cyc();
        flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h308, 32'h00300193);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        at_neg();
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        cyc(); cyc();
        at_neg();
        chk("flush_gone", 32'(bus.out_valid), 32'h0);

        // All-zero word, then jal x0,0
        drive(1'b1, 32'h400, 32'h00000000);
        cyc();
        drive(1'b1, 32'h404, 32'h0000006F);
        at_neg();
        chk("zero_ill", 32'(bus.illegal), 32'h1);
        chk("zero_we",  32'(bus.rd_we),   32'h0);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        at_neg();
        chk("jal_pc",   bus.out_pc,         32'h404);
        chk("jal_ill",  32'(bus.illegal),   32'h0);
        chk("jal_we",   32'(bus.rd_we),     32'h0);
        chk("jal_imm",  bus.imm,            32'h0);
        chk("jal_type", 32'(bus.imm_type),  32'(IMM_J));
        cyc();

        // mul x3,x1,x2
        drive(1'b1, 32'h500, 32'h022081B3);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        at_neg();
`ifdef DECODE_MULDIV_EN
        chk("mul_ill", 32'(bus.illegal), 32'h0);
        chk("mul_we",  32'(bus.rd_we),   32'h1);
`else
        chk("mul_ill", 32'(bus.illegal), 32'h1);
        chk("mul_we",  32'(bus.rd_we),   32'h0);
`endif
        cyc();

        // Mixed vectors under random valid/ready, checked by the model
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 4), vec[i % 20]);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            cyc();
        end
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Reset with entries buffered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h00100093);
        cyc();
        drive(1'b1, 32'h604, 32'h00200113);
        cyc();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        at_neg();
        chk("midrst_valid", 32'(bus.out_valid), 32'h0);
        chk("midrst_pc",    bus.out_pc,         32'h0);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
